// File: rtl/key_expansion_iter.sv
// key_expansion_iter: iterative AES key schedule, one 128-bit round key per
// accepted handshake, with an optional registered-read round-key store.
// Build macro KEY_EXP_AES256_EN enables AES-256 (store depth 15); without it
// the block is AES-128 only (store depth 11) and key_len is ignored.
module key_expansion_iter #(
  parameter int unsigned CLEAR_ON_START = 1,
  parameter int unsigned RK_STORE_EN    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic         key_len,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

`ifdef KEY_EXP_AES256_EN
  localparam int unsigned DEPTH = 15;
`else
  localparam int unsigned DEPTH = 11;
`endif
  localparam logic [3:0] LAST_ENTRY = 4'(DEPTH - 1);

  logic [1:0]   state_q;
  logic         rk_valid_q;
  logic [127:0] rk_data_q;
  logic [127:0] prev_q;
  logic [3:0]   rk_idx_q;
  logic         aes256_q;
  logic         start_256;
  logic         accept;
  logic         xfer;
  logic [3:0]   last_idx;
  logic [3:0]   idx_nx;
  logic [31:0]  sub_w;
  logic [31:0]  rot_w;
  logic [31:0]  t_w;
  logic [127:0] base_w;
  logic [31:0]  w0_d, w1_d, w2_d, w3_d;
  logic [127:0] key_d;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, 0 maps to 0) then affine transform
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(b, b);
    inv = sq;
    for (int unsigned i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

`ifdef KEY_EXP_AES256_EN
  assign start_256 = key_len;

  // Key length is captured only when a start is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      aes256_q <= 1'b0;
    end else if (accept) begin
      aes256_q <= key_len;
    end
  end
`else
  logic unused_key_len;
  assign unused_key_len = key_len;
  assign start_256      = 1'b0;
  assign aes256_q       = 1'b0;
`endif

  assign accept   = (state_q == S_IDLE) && start;
  assign xfer     = rk_valid_q && rk_ready;
  assign last_idx = aes256_q ? 4'd14 : 4'd10;
  assign idx_nx   = rk_idx_q + 4'd1;

  // Single 4-byte S-box bank on the last word; RotWord commutes with SubWord
  // so rotation is applied after substitution.
  assign sub_w = {sbox(rk_data_q[31:24]), sbox(rk_data_q[23:16]),
                  sbox(rk_data_q[15:8]),  sbox(rk_data_q[7:0])};
  assign rot_w = {sub_w[23:0], sub_w[31:24]};

  // Next round key: AES-128 chains into the current key, AES-256 into k-1
  always_comb begin
    t_w    = rot_w ^ {rcon(idx_nx), 24'h0};
    base_w = rk_data_q;
    if (aes256_q) begin
      base_w = prev_q;
      if (idx_nx[0]) t_w = sub_w;
      else           t_w = rot_w ^ {rcon({1'b0, idx_nx[3:1]}), 24'h0};
    end
    w0_d  = base_w[127:96] ^ t_w;
    w1_d  = base_w[95:64]  ^ w0_d;
    w2_d  = base_w[63:32]  ^ w1_d;
    w3_d  = base_w[31:0]   ^ w2_d;
    key_d = {w0_d, w1_d, w2_d, w3_d};
    // AES-256 rk1 is the lower key half, parked in prev_q at start
    if (aes256_q && (rk_idx_q == 4'd0)) key_d = prev_q;
  end

  // Control FSM and round-key output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      prev_q     <= '0;
      rk_idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rk_data_q  <= start_256 ? key_in[255:128] : key_in[127:0];
            prev_q     <= key_in[127:0];
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b1;
            state_q    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (xfer) begin
            if (rk_idx_q == last_idx) begin
              rk_valid_q <= 1'b0;
              state_q    <= S_FIN;
            end else begin
              rk_data_q <= key_d;
              prev_q    <= rk_data_q;
              rk_idx_q  <= idx_nx;
            end
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q == S_EMIT);
  assign done     = (state_q == S_FIN);
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;

  generate
    if (RK_STORE_EN != 0) begin : g_store
      logic [127:0] store_q [DEPTH];
      logic [127:0] rd_key_q;

      // Round-key store: write on transfer, registered read returns pre-write data
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < DEPTH; i++) store_q[i] <= '0;
          rd_key_q <= '0;
        end else begin
          if (rd_idx <= LAST_ENTRY) rd_key_q <= store_q[rd_idx];
          else                      rd_key_q <= '0;
          if (accept && (CLEAR_ON_START != 0)) begin
            for (int unsigned i = 0; i < DEPTH; i++) store_q[i] <= '0;
          end else if (xfer) begin
            store_q[rk_idx_q] <= rk_data_q;
          end
        end
      end

      assign rd_key = rd_key_q;
    end else begin : g_nostore
      logic unused_rd_idx;
      assign unused_rd_idx = ^rd_idx;
      assign rd_key        = '0;
    end
  endgenerate

endmodule
